// File: rtl/mc_ctrl_seq.sv
// Multi-cycle RV32I control sequencer: owns pc/pc0/ir, handshakes with variable-latency memories,
// traps on illegal opcodes or misaligned targets, counts retired instructions. Option: MC_WAIT_TIMEOUT_EN.
module mc_ctrl_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32,
  parameter int              TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  F,
  input  logic             zf,
  input  logic             sf,
  input  logic             cf,
  input  logic             of,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc0,
  output logic [31:0]      ir,
  output logic             reg_write,
  output logic [2:0]       w_data_s,
  output logic             rs2_imm_s,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // S_EXEC_F is the second EXEC cycle, where the registered F and flags are valid.
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_EXEC_F, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc_d, pc0_d, tgt, tgt_d;
  logic [31:0]     ir_d;
  logic            retire;
  logic            timeout_hit;

  logic [2:0] f3;
  logic is_r, is_ialu, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic legal;
  logic [XLEN-1:0] br_tgt, jalr_tgt;

  function automatic logic br_taken(input logic [2:0] fn, input logic z, input logic s,
                                    input logic c, input logic o);
    unique case (fn)
      3'b000:  br_taken = z;
      3'b001:  br_taken = !z;
      3'b100:  br_taken = s ^ o;
      3'b101:  br_taken = !(s ^ o);
      3'b110:  br_taken = c;
      3'b111:  br_taken = !c;
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    misaligned = (addr[1:0] != 2'b00);
  endfunction

  assign f3       = ir[14:12];
  assign is_r     = (ir[6:0] == OP_R);
  assign is_ialu  = (ir[6:0] == OP_IALU);
  assign is_load  = (ir[6:0] == OP_LOAD);
  assign is_store = (ir[6:0] == OP_STORE);
  assign is_br    = (ir[6:0] == OP_BR);
  assign is_jal   = (ir[6:0] == OP_JAL);
  assign is_jalr  = (ir[6:0] == OP_JALR);
  assign is_lui   = (ir[6:0] == OP_LUI);
  assign is_auipc = (ir[6:0] == OP_AUIPC);
  assign legal    = (is_r | is_ialu | is_load | is_store | is_jal | is_jalr | is_lui | is_auipc) |
                    (is_br && (f3[2:1] != 2'b01));

  assign br_tgt    = pc0 + imm;
  assign jalr_tgt  = F & ~XLEN'(1);
  assign imem_addr = pc;
  assign halted    = (state == S_TRAP);

`ifdef MC_WAIT_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            waiting;

  assign waiting     = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);
  assign timeout_hit = waiting && (wait_cnt == WC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                        wait_cnt <= '0;
    else if (waiting && !timeout_hit) wait_cnt <= wait_cnt + WC_W'(1);
    else                              wait_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pc0_d     = pc0;
    ir_d      = ir;
    tgt_d     = tgt;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    w_data_s  = 3'd0;
    rs2_imm_s = 1'b0;
    unique case (state)
      S_FETCH: begin
        // Held low during reset so no fetch is issued before release.
        imem_req = rst_;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc0_d   = pc;
          pc_d    = pc + XLEN'(4);
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        rs2_imm_s = is_ialu | is_load | is_store | is_jalr;
        if (is_r || is_ialu || is_lui || is_auipc) state_d = S_WB;
        else if (is_load || is_store)              state_d = S_MEM;
        else if (is_br || is_jalr)                 state_d = S_EXEC_F;
        else if (is_jal) begin
          tgt_d   = br_tgt;
          state_d = misaligned(br_tgt) ? S_TRAP : S_WB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC_F: begin
        rs2_imm_s = is_jalr;
        if (is_jalr) begin
          tgt_d   = jalr_tgt;
          state_d = misaligned(jalr_tgt) ? S_TRAP : S_WB;
        end else if (br_taken(f3, zf, sf, cf, of) && misaligned(br_tgt)) begin
          state_d = S_TRAP;
        end else begin
          if (br_taken(f3, zf, sf, cf, of)) pc_d = br_tgt;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_lui)                w_data_s = 3'd1;
        else if (is_load)          w_data_s = 3'd2;
        else if (is_jal | is_jalr) w_data_s = 3'd3;
        else if (is_auipc)         w_data_s = 3'd4;
        // Jump target lands only after the link value (pc0+4) has been written.
        if (is_jal | is_jalr) pc_d = tgt;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      pc0     <= '0;
      ir      <= '0;
      instret <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      pc0   <= pc0_d;
      ir    <= ir_d;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    tgt <= tgt_d;
  end

endmodule
